// File: rtl/ecc_op_sequencer_pkg.sv
// Shared ECC control types: operation/width encodings, sequencer states and config legality check.
package ecc_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ENC  = 2'd0,
    OP_DEC  = 2'd1,
    OP_FULL = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    W8  = 2'd0,
    W16 = 2'd1,
    W32 = 2'd2
  } width_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENCODE,
    S_NOISE,
    S_DECODE,
    S_DONE
  } seq_state_e;

  function automatic logic cfg_legal(input logic [1:0] op, input logic [1:0] width);
    return (op inside {OP_ENC, OP_DEC, OP_FULL}) && (width inside {W8, W16, W32});
  endfunction

endpackage

// File: rtl/ecc_op_sequencer_if.sv
// Handshake bundle between the op sequencer (master) and the ECC datapath stages (slave).
interface ecc_op_sequencer_if;
  logic       enc_start;
  logic       enc_done;
  logic       noise_apply;
  logic       dec_start;
  logic       dec_done;
  logic [1:0] dec_num_err;
  logic [1:0] width_q;

  modport master (
    output enc_start, noise_apply, dec_start, width_q,
    input  enc_done, dec_done, dec_num_err
  );

  modport slave (
    input  enc_start, noise_apply, dec_start, width_q,
    output enc_done, dec_done, dec_num_err
  );
endinterface

// File: rtl/ecc_op_sequencer_watchdog.sv
// Wait-state watchdog for the ECC sequencer; only present when ECC_SEQ_TIMEOUT_EN is defined.
`ifdef ECC_SEQ_TIMEOUT_EN
module ecc_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of wait cycles already spent before the current one
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule
`endif

// File: rtl/ecc_op_sequencer.sv
// Sequences encoder -> noise -> decoder after an APB start pulse; reports done, error count, status.
// Optional wait-state timeout enabled by defining ECC_SEQ_TIMEOUT_EN.
module ecc_op_sequencer
  import ecc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               ctrl_op,
  input  logic [1:0]               cw_width_sel,
  ecc_op_sequencer_if.master       dp,
  output logic                     busy,
  output logic                     operation_done,
  output logic [1:0]               num_of_errors,
  output logic                     error_flag
);
  seq_state_e state_q, state_d;
  logic [1:0] op_q, op_d, width_q, width_d, nerr_q, nerr_d;
  logic       eflag_q, eflag_d;
  logic       enc_start_q, enc_start_d, noise_q, noise_d;
  logic       dec_start_q, dec_start_d, done_q, done_d;
  logic       wd_expired;

  if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

`ifdef ECC_SEQ_TIMEOUT_EN
  logic wd_run, wd_clr;
  assign wd_run = (state_q == S_ENCODE) || (state_q == S_DECODE);
  assign wd_clr = !wd_run || (state_d != state_q);

  ecc_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .run    (wd_run),
    .clr    (wd_clr),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    width_d = width_q;
    nerr_d  = nerr_q;
    eflag_d = eflag_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = ctrl_op;
          width_d = cw_width_sel;
          nerr_d  = '0;
          eflag_d = 1'b0;
          if (!cfg_legal(ctrl_op, cw_width_sel)) begin
            state_d = S_DONE;
            eflag_d = 1'b1;
          end else if (ctrl_op == OP_DEC) begin
            state_d = S_DECODE;
          end else begin
            state_d = S_ENCODE;
          end
        end
      end
      // *_start_q is high only in the first wait cycle, which masks a stale done level
      S_ENCODE: begin
        if (!enc_start_q && dp.enc_done) begin
          state_d = (op_q == OP_FULL) ? S_NOISE : S_DONE;
        end else if (wd_expired) begin
          state_d = S_DONE;
          eflag_d = 1'b1;
          nerr_d  = '1;
        end
      end
      S_NOISE: state_d = S_DECODE;
      S_DECODE: begin
        if (!dec_start_q && dp.dec_done) begin
          state_d = S_DONE;
          nerr_d  = dp.dec_num_err;
        end else if (wd_expired) begin
          state_d = S_DONE;
          eflag_d = 1'b1;
          nerr_d  = '1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    enc_start_d = (state_d == S_ENCODE) && (state_q != S_ENCODE);
    dec_start_d = (state_d == S_DECODE) && (state_q != S_DECODE);
    noise_d     = (state_d == S_NOISE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      width_q     <= '0;
      nerr_q      <= '0;
      eflag_q     <= 1'b0;
      enc_start_q <= 1'b0;
      noise_q     <= 1'b0;
      dec_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      width_q     <= width_d;
      nerr_q      <= nerr_d;
      eflag_q     <= eflag_d;
      enc_start_q <= enc_start_d;
      noise_q     <= noise_d;
      dec_start_q <= dec_start_d;
      done_q      <= done_d;
    end
  end

  assign dp.enc_start   = enc_start_q;
  assign dp.noise_apply = noise_q;
  assign dp.dec_start   = dec_start_q;
  assign dp.width_q     = width_q;
  assign busy           = (state_q != S_IDLE);
  assign operation_done = done_q;
  assign num_of_errors  = nerr_q;
  assign error_flag     = eflag_q;
endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Self-checking bench for ecc_op_sequencer: vector table, random ops against a timeline model, corner sequences.
module tb_ecc_op_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] ctrl_op;
  logic [1:0] cw_width_sel;
  logic       busy;
  logic       operation_done;
  logic [1:0] num_of_errors;
  logic       error_flag;

  ecc_op_sequencer_if dp_if ();

  ecc_op_sequencer #(
    .TIMEOUT_CYCLES(8),
    .CNT_W         (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .ctrl_op       (ctrl_op),
    .cw_width_sel  (cw_width_sel),
    .dp            (dp_if),
    .busy          (busy),
    .operation_done(operation_done),
    .num_of_errors (num_of_errors),
    .error_flag    (error_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // cycle stamps are counted from the cycle in which start is high (cycle 0); lat is inclusive
  typedef struct {
    int es, es_n, na, na_n, ds, ds_n, lat, nerr, ef;
  } exp_t;

  typedef struct {
    logic [1:0] op, w;
    int         le, ld;
    logic [1:0] ne;
    int         lat;
    int         nerr;
    int         ef;
  } vec_t;

  exp_t obs;
  int   busy_gap, width_bad, done_n, busy_after;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs_vec();
    return int'({busy, operation_done, num_of_errors, error_flag, dp_if.enc_start,
                 dp_if.noise_apply, dp_if.dec_start, dp_if.width_q});
  endfunction

  // Timeline from the spec's state sequence: each wait state lasts until done is seen
  // latency cycles after its start pulse; NOISE and DONE are single cycles.
  function automatic exp_t model(input logic [1:0] op, input logic [1:0] w,
                                 input int le, input int ld, input logic [1:0] ne);
    exp_t e = '{es: -1, es_n: 0, na: -1, na_n: 0, ds: -1, ds_n: 0, lat: -1, nerr: 0, ef: 0};
    if (op == 2'd3 || w == 2'd3) begin
      e.lat = 2;
      e.ef  = 1;
    end else if (op == 2'd0) begin
      e.es = 1; e.es_n = 1;
      e.lat = le + 3;
    end else if (op == 2'd1) begin
      e.ds = 1; e.ds_n = 1;
      e.lat = ld + 3;
      e.nerr = int'(ne);
    end else begin
      e.es = 1; e.es_n = 1;
      e.na = le + 2; e.na_n = 1;
      e.ds = le + 3; e.ds_n = 1;
      e.lat = le + ld + 5;
      e.nerr = int'(ne);
    end
    return e;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [1:0] w, input int le, input int ld,
                        input logic [1:0] ne, input int restart_k);
    int k, enc_at, dec_at, done_k;
    obs = '{es: -1, es_n: 0, na: -1, na_n: 0, ds: -1, ds_n: 0, lat: -1, nerr: -1, ef: -1};
    busy_gap = 0; width_bad = 0; done_n = 0; busy_after = -1;
    enc_at = -1; dec_at = -1; done_k = -1;
    start = 1'b1; ctrl_op = op; cw_width_sel = w;
    tick();
    k = 1;
    while (k < 200 && (done_k < 0 || k <= done_k + 3)) begin
      start        = (k == restart_k);
      ctrl_op      = 2'($urandom);
      cw_width_sel = 2'($urandom);
      if (dp_if.enc_start) begin
        obs.es_n++;
        if (obs.es < 0) obs.es = k;
        enc_at = k + le;
      end
      if (dp_if.noise_apply) begin
        obs.na_n++;
        if (obs.na < 0) obs.na = k;
      end
      if (dp_if.dec_start) begin
        obs.ds_n++;
        if (obs.ds < 0) obs.ds = k;
        dec_at = k + ld;
      end
      if (done_k < 0) begin
        if (!busy) busy_gap++;
        if (busy && dp_if.width_q != w) width_bad++;
      end
      if (operation_done) begin
        done_n++;
        if (done_k < 0) begin
          done_k   = k;
          obs.lat  = k + 1;
          obs.nerr = int'(num_of_errors);
          obs.ef   = int'(error_flag);
        end
      end
      if (done_k >= 0 && k == done_k + 1) busy_after = int'(busy);
      dp_if.enc_done    = (k == enc_at);
      dp_if.dec_done    = (k == dec_at);
      dp_if.dec_num_err = (k == dec_at) ? ne : 2'($urandom);
      tick();
      k++;
    end
    start = 1'b0;
    dp_if.enc_done = 1'b0;
    dp_if.dec_done = 1'b0;
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, ".enc_start_cyc"}, obs.es, e.es);
    check({tag, ".enc_start_cnt"}, obs.es_n, e.es_n);
    check({tag, ".noise_cyc"}, obs.na, e.na);
    check({tag, ".noise_cnt"}, obs.na_n, e.na_n);
    check({tag, ".dec_start_cyc"}, obs.ds, e.ds);
    check({tag, ".dec_start_cnt"}, obs.ds_n, e.ds_n);
    check({tag, ".latency"}, obs.lat, e.lat);
    check({tag, ".num_err"}, obs.nerr, e.nerr);
    check({tag, ".err_flag"}, obs.ef, e.ef);
    check({tag, ".busy_gap"}, busy_gap, 0);
    check({tag, ".width_hold"}, width_bad, 0);
    check({tag, ".done_cnt"}, done_n, 1);
    check({tag, ".busy_after"}, busy_after, 0);
    check({tag, ".num_err_held"}, int'(num_of_errors), e.nerr);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    vec_t vecs[7];
    exp_t e;
    int   anomalies;
    logic [1:0] r_op, r_w, r_ne;
    int   r_le, r_ld, r_rk;

    vecs[0] = '{2'd2, 2'd1, 1, 1, 2'd1, 7, 1, 0};
    vecs[1] = '{2'd3, 2'd0, 1, 1, 2'd2, 2, 0, 1};
    vecs[2] = '{2'd0, 2'd2, 1, 1, 2'd3, 4, 0, 0};
    vecs[3] = '{2'd1, 2'd0, 1, 1, 2'd2, 4, 2, 0};
    vecs[4] = '{2'd0, 2'd3, 1, 1, 2'd1, 2, 0, 1};
    vecs[5] = '{2'd2, 2'd2, 3, 2, 2'd3, 10, 3, 0};
    vecs[6] = '{2'd1, 2'd1, 4, 4, 2'd0, 7, 0, 0};

    rst = 1'b1; start = 1'b0; ctrl_op = '0; cw_width_sel = '0;
    dp_if.enc_done = 1'b0; dp_if.dec_done = 1'b0; dp_if.dec_num_err = '0;
    tick();
    tick();
    check("reset_outputs", outs_vec(), 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].w, vecs[i].le, vecs[i].ld, vecs[i].ne, -1);
      check($sformatf("vec%0d.latency", i), obs.lat, vecs[i].lat);
      check($sformatf("vec%0d.num_err", i), obs.nerr, vecs[i].nerr);
      check($sformatf("vec%0d.err_flag", i), obs.ef, vecs[i].ef);
      check($sformatf("vec%0d.done_cnt", i), done_n, 1);
      check($sformatf("vec%0d.width_hold", i), width_bad, 0);
    end

    // FULL with a DECODE request arriving while in ENCODE: must still run as FULL
    run_op(2'd2, 2'd1, 2, 1, 2'd2, 1);
    compare_all("busy_start", model(2'd2, 2'd1, 2, 1, 2'd2));
    // start presented during the DONE cycle is dropped
    run_op(2'd0, 2'd0, 1, 1, 2'd0, 3);
    compare_all("start_in_done", model(2'd0, 2'd0, 1, 1, 2'd0));

    for (int n = 0; n < 30; n++) begin
      r_op = 2'($urandom_range(0, 3));
      r_w  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_le = $urandom_range(1, 5);
      r_ld = $urandom_range(1, 5);
      r_ne = 2'($urandom);
      r_rk = ($urandom_range(0, 1) == 1) ? 1 : -1;
      run_op(r_op, r_w, r_le, r_ld, r_ne, r_rk);
      compare_all($sformatf("rnd%0d", n), model(r_op, r_w, r_le, r_ld, r_ne));
    end

    // stale enc_done level from before start must not complete ENCODE in its first cycle
    dp_if.enc_done = 1'b1;
    start = 1'b1; ctrl_op = 2'd0; cw_width_sel = 2'd0;
    tick();
    start = 1'b0;
    check("early_done.enc_start", int'(dp_if.enc_start), 1);
    tick();
    check("early_done.ignored", int'(operation_done), 0);
    check("early_done.busy", int'(busy), 1);
    tick();
    check("early_done.accepted", int'(operation_done), 1);
    dp_if.enc_done = 1'b0;
    tick();

    // start in the cycle right after DONE is accepted
    start = 1'b1; ctrl_op = 2'd0; cw_width_sel = 2'd1;
    tick();
    start = 1'b0;
    tick();
    dp_if.enc_done = 1'b1;
    tick();
    dp_if.enc_done = 1'b0;
    check("back2back.first_done", int'(operation_done), 1);
    tick();
    start = 1'b1; ctrl_op = 2'd1; cw_width_sel = 2'd0;
    tick();
    start = 1'b0;
    check("back2back.dec_start", int'(dp_if.dec_start), 1);
    tick();
    dp_if.dec_done = 1'b1; dp_if.dec_num_err = 2'd1;
    tick();
    dp_if.dec_done = 1'b0;
    check("back2back.second_done", int'(operation_done), 1);
    check("back2back.num_err", int'(num_of_errors), 1);
    tick();

    // reset mid-DECODE aborts; a late dec_done does nothing
    start = 1'b1; ctrl_op = 2'd1; cw_width_sel = 2'd2;
    tick();
    start = 1'b0;
    tick();
    check("rst_mid.busy_before", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid.outputs", outs_vec(), 0);
    dp_if.dec_done = 1'b1; dp_if.dec_num_err = 2'd3;
    anomalies = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (outs_vec() != 0) anomalies++;
    end
    dp_if.dec_done = 1'b0;
    check("rst_mid.late_dec_done", anomalies, 0);
    tick();

`ifdef ECC_SEQ_TIMEOUT_EN
    e = '{es: 1, es_n: 1, na: -1, na_n: 0, ds: -1, ds_n: 0, lat: 10, nerr: 3, ef: 1};
    run_op(2'd0, 2'd0, 20, 1, 2'd0, -1);
    compare_all("enc_timeout", e);
    e = '{es: -1, es_n: 0, na: -1, na_n: 0, ds: 1, ds_n: 1, lat: 10, nerr: 3, ef: 1};
    run_op(2'd1, 2'd0, 1, 20, 2'd2, -1);
    compare_all("dec_timeout", e);
`else
    run_op(2'd0, 2'd0, 20, 1, 2'd0, -1);
    compare_all("enc_long_wait", model(2'd0, 2'd0, 20, 1, 2'd0));
    run_op(2'd1, 2'd0, 1, 20, 2'd2, -1);
    compare_all("dec_long_wait", model(2'd1, 2'd0, 1, 20, 2'd2));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
